// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the byte type used by the receiver,
//               the receive FIFO and the APB register block.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_RXFIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x DATA_W storage array, synchronous write port and
//               asynchronous read port. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_RXFIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write one entry on an accepted push; no reset so it maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the head byte falls through without a bubble.
    assign rdata = r_mem[raddr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-byte FIFO between the UART receiver and the register
//               block. First-word-fall-through head, occupancy count and a
//               sticky overrun flag. Optional registered threshold flag is
//               enabled by defining UART_RXFIFO_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_RXFIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
`ifdef UART_RXFIFO_THRESH_EN
    ,
    parameter int THRESH = DEPTH / 2
`endif
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
`ifdef UART_RXFIFO_THRESH_EN
    ,
    output logic              rx_thresh
`endif
);

    localparam logic [ADDR_W:0]   C_FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;
    logic [ADDR_W:0]   w_count_next;
    logic              w_empty;
    logic              w_full;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_ovr_set;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;

    // Flags come from the count only; equal pointers are ambiguous.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL_COUNT);

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = rx_done && (!w_full || pop);
    assign w_ovr_set = rx_done && w_full && !pop;
    assign w_mem_we  = w_push_ok && !flush;

    // Next occupancy: flush wins, otherwise a simultaneous push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + C_CNT_ONE;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - C_CNT_ONE;
        end
    end

    // Pointer, count and sticky overrun state.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
            end
            r_count <= w_count_next;
            // Set beats clear so a drop in the clearing cycle is not lost.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (pClk),
        .we    (w_mem_we),
        .waddr (r_wr_ptr),
        .wdata (rx_data),
        .raddr (r_rd_ptr),
        .rdata (w_mem_rdata)
    );

    assign rd_data = w_empty ? '0 : w_mem_rdata;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

`ifdef UART_RXFIFO_THRESH_EN
    localparam logic [ADDR_W:0] C_THRESH = (ADDR_W + 1)'(THRESH);

    logic r_rx_thresh;

    // Threshold tracks the post-edge occupancy so it aligns with count.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_rx_thresh <= 1'b0;
        end else begin
            r_rx_thresh <= (w_count_next >= C_THRESH);
        end
    end

    assign rx_thresh = r_rx_thresh;
`endif

endmodule : uart_rx_fifo
`default_nettype wire
